// File: rtl/block_mult_scheduler_pkg.sv
// Shared definitions for the 2x2-tiled matrix-multiply scheduler.
//   state_e  : scheduler FSM states
//   Slot*    : operand slot numbers carried on op_idx (A tile first, then B tile)
//   pad_dim  : rounds a matrix dimension up to the next even value
package block_mult_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StFetch,
        StWait,
        StStep,
        StOut,
        StDone
    } state_e;

    // Bit 2 selects the B tile, bit 1 the row, bit 0 the column within the tile.
    localparam logic [2:0] SlotA00 = 3'd0;
    localparam logic [2:0] SlotA01 = 3'd1;
    localparam logic [2:0] SlotA10 = 3'd2;
    localparam logic [2:0] SlotA11 = 3'd3;
    localparam logic [2:0] SlotB00 = 3'd4;
    localparam logic [2:0] SlotB01 = 3'd5;
    localparam logic [2:0] SlotB10 = 3'd6;
    localparam logic [2:0] SlotB11 = 3'd7;

    // Dimensions are at most 31 bits wide, so the +1 cannot overflow.
    function automatic logic [31:0] pad_dim(input logic [31:0] d);
        return d + {31'b0, d[0]};
    endfunction

endpackage

// File: rtl/block_addr_gen.sv
// Operand address calculator for one word of a 2x2 tile pair.
//   tile_i_i, tile_j_i, step_k_i : current output tile (i, j) and k-step
//   slot_i                       : operand slot (A00..B11)
//   jp_i, cp_i, bb_i             : padded joint/col2 sizes and base of matrix 2
//   addr_o                       : word address of the requested operand
// Purely combinational. Every legal address is below MEMORY_HEIGHT, so
// arithmetic modulo 2**ADDR_W yields the exact result.
module block_addr_gen
    import block_mult_scheduler_pkg::*;
#(
    parameter int unsigned DIM_W  = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic [DIM_W-1:0]  tile_i_i,
    input  logic [DIM_W-1:0]  tile_j_i,
    input  logic [DIM_W-1:0]  step_k_i,
    input  logic [2:0]        slot_i,
    input  logic [ADDR_W-1:0] jp_i,
    input  logic [ADDR_W-1:0] cp_i,
    input  logic [ADDR_W-1:0] bb_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic              r;
    logic              c;
    logic [ADDR_W-1:0] row;

    always_comb begin
        r      = slot_i[1];
        c      = slot_i[0];
        row    = '0;
        addr_o = '0;
        if (slot_i >= SlotB00) begin
            // B(k,j): row 2k+r of matrix 2, column 2j+c
            row    = ADDR_W'({step_k_i, r});
            addr_o = bb_i + row * cp_i + ADDR_W'({tile_j_i, c});
        end else begin
            // A(i,k): row 2i+r of matrix 1, column 2k+c
            row    = ADDR_W'({tile_i_i, r});
            addr_o = row * jp_i + ADDR_W'({step_k_i, c});
        end
    end

endmodule

// File: rtl/block_mult_scheduler.sv
// Sequencing controller for the 2x2-tiled matrix-multiply datapath.
//   start, row1, joint, col2 : launch request and unpadded dimensions
//   busy, done, err          : run status
//   rd_en, rd_addr           : operand memory read port (data one cycle later)
//   op_valid, op_idx         : slot tag aligned with returning read data
//   mac_step/first/last      : multiply-accumulate strobes
//   out_valid/ready/row/col  : finished-tile handshake towards write-back
module block_mult_scheduler
    import block_mult_scheduler_pkg::*;
#(
    parameter int unsigned MEMORY_HEIGHT = 4000,
    parameter int unsigned DIM_W         = 16,
    parameter int unsigned ADDR_W        = $clog2(MEMORY_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  row1,
    input  logic [DIM_W-1:0]  joint,
    input  logic [DIM_W-1:0]  col2,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              op_valid,
    output logic [2:0]        op_idx,
    output logic              mac_step,
    output logic              mac_first,
    output logic              mac_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col
);

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  row1_q, row1_d, joint_q, joint_d, col2_q, col2_d;
    logic [DIM_W-1:0]  it_q, it_d, kt_q, kt_d, ct_q, ct_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ADDR_W-1:0] jp_q, jp_d, cp_q, cp_d, bb_q, bb_d;
    logic [2:0]        slot_q, slot_d;
    logic              err_q, err_d;
    logic              op_valid_q;
    logic [2:0]        op_idx_q;

    logic [31:0]       rp, jp, cp;
    logic [63:0]       size_a, size_b;
    logic              dim_zero, too_big;
    logic              last_i, last_j, last_k;
    logic [ADDR_W-1:0] fetch_addr;

    // Footprint computed wide so the overflow check sees the true size.
    always_comb begin
        rp       = pad_dim(32'(row1_q));
        jp       = pad_dim(32'(joint_q));
        cp       = pad_dim(32'(col2_q));
        size_a   = 64'(rp) * 64'(jp);
        size_b   = 64'(jp) * 64'(cp);
        dim_zero = (row1_q == '0) || (joint_q == '0) || (col2_q == '0);
        too_big  = (size_a + size_b) > 64'(MEMORY_HEIGHT);
    end

    assign last_i = (i_q == it_q - DIM_W'(1));
    assign last_j = (j_q == ct_q - DIM_W'(1));
    assign last_k = (k_q == kt_q - DIM_W'(1));

    block_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .tile_i_i (i_q),
        .tile_j_i (j_q),
        .step_k_i (k_q),
        .slot_i   (slot_q),
        .jp_i     (jp_q),
        .cp_i     (cp_q),
        .bb_i     (bb_q),
        .addr_o   (fetch_addr)
    );

    always_comb begin
        state_d = state_q;
        row1_d  = row1_q;
        joint_d = joint_q;
        col2_d  = col2_q;
        it_d    = it_q;
        kt_d    = kt_q;
        ct_d    = ct_q;
        jp_d    = jp_q;
        cp_d    = cp_q;
        bb_d    = bb_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        slot_d  = slot_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row1_d  = row1;
                    joint_d = joint;
                    col2_d  = col2;
                    err_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (dim_zero || too_big) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    it_d    = DIM_W'(rp >> 1);
                    kt_d    = DIM_W'(jp >> 1);
                    ct_d    = DIM_W'(cp >> 1);
                    jp_d    = ADDR_W'(jp);
                    cp_d    = ADDR_W'(cp);
                    bb_d    = ADDR_W'(size_a);
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    slot_d  = SlotA00;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // slot wraps back to A00 after B11, ready for the next fetch
                slot_d = slot_q + 3'd1;
                if (slot_q == SlotB11) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                state_d = StStep;
            end
            StStep: begin
                if (last_k) begin
                    state_d = StOut;
                end else begin
                    k_d     = k_q + DIM_W'(1);
                    state_d = StFetch;
                end
            end
            StOut: begin
                if (out_ready) begin
                    k_d = '0;
                    if (last_j) begin
                        j_d = '0;
                        if (last_i) begin
                            i_d     = '0;
                            state_d = StDone;
                        end else begin
                            i_d     = i_q + DIM_W'(1);
                            state_d = StFetch;
                        end
                    end else begin
                        j_d     = j_q + DIM_W'(1);
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            row1_q     <= '0;
            joint_q    <= '0;
            col2_q     <= '0;
            it_q       <= '0;
            kt_q       <= '0;
            ct_q       <= '0;
            jp_q       <= '0;
            cp_q       <= '0;
            bb_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            slot_q     <= '0;
            err_q      <= 1'b0;
            op_valid_q <= 1'b0;
            op_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            row1_q     <= row1_d;
            joint_q    <= joint_d;
            col2_q     <= col2_d;
            it_q       <= it_d;
            kt_q       <= kt_d;
            ct_q       <= ct_d;
            jp_q       <= jp_d;
            cp_q       <= cp_d;
            bb_q       <= bb_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            slot_q     <= slot_d;
            err_q      <= err_d;
            // Tag follows the read by one cycle to line up with memory data.
            op_valid_q <= (state_q == StFetch);
            op_idx_q   <= (state_q == StFetch) ? slot_q : 3'd0;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = (state_q == StDone);
        err       = err_q;
        rd_en     = (state_q == StFetch);
        rd_addr   = rd_en ? fetch_addr : '0;
        op_valid  = op_valid_q;
        op_idx    = op_idx_q;
        mac_step  = (state_q == StStep);
        mac_first = mac_step && (k_q == '0);
        mac_last  = mac_step && last_k;
        out_valid = (state_q == StOut);
        out_row   = out_valid ? i_q : '0;
        out_col   = out_valid ? j_q : '0;
    end

endmodule

// File: tb/tb_block_mult_scheduler.sv
// Self-checking bench for block_mult_scheduler. Each run is expanded from the
// tiling rules into a per-cycle table of expected outputs and driven inputs;
// the DUT is compared against it cycle by cycle.
module tb_block_mult_scheduler;

    localparam int MemH  = 4000;
    localparam int DimW  = 16;
    localparam int AddrW = 12;

    // Bit positions in the packed control vector.
    localparam int BBusy  = 8;
    localparam int BDone  = 7;
    localparam int BErr   = 6;
    localparam int BRd    = 5;
    localparam int BOpv   = 4;
    localparam int BStep  = 3;
    localparam int BFirst = 2;
    localparam int BLast  = 1;
    localparam int BOv    = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DimW-1:0]  row1, joint, col2;
    logic             busy, done, err, rd_en, op_valid;
    logic [AddrW-1:0] rd_addr;
    logic [2:0]       op_idx;
    logic             mac_step, mac_first, mac_last, out_valid, out_ready;
    logic [DimW-1:0]  out_row, out_col;
    logic [8:0]       obs_ctrl;

    assign obs_ctrl = {busy, done, err, rd_en, op_valid, mac_step, mac_first, mac_last,
                       out_valid};

    block_mult_scheduler #(
        .MEMORY_HEIGHT (MemH),
        .DIM_W         (DimW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .row1      (row1),
        .joint     (joint),
        .col2      (col2),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .op_valid  (op_valid),
        .op_idx    (op_idx),
        .mac_step  (mac_step),
        .mac_first (mac_first),
        .mac_last  (mac_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit   start;
        bit   ready;
        int   r1;
        int   jt;
        int   c2;
        bit [8:0] ctrl;
        int   addr;
        int   idx;
        int   orow;
        int   ocol;
    } cyc_t;

    cyc_t tl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   prev_err = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Idle-looking cycle with random don't-care inputs.
    function automatic cyc_t blank(bit rand_start);
        cyc_t c;
        c.start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
        c.ready = 1'($urandom_range(0, 1));
        c.r1    = $urandom_range(0, 65535);
        c.jt    = $urandom_range(0, 65535);
        c.c2    = $urandom_range(0, 65535);
        c.ctrl  = '0;
        c.addr  = 0;
        c.idx   = 0;
        c.orow  = 0;
        c.ocol  = 0;
        return c;
    endfunction

    task automatic build(input int r1, input int jt, input int c2, input int slo,
                         input int shi, input bit rs);
        cyc_t   c;
        int     rp, jp, cp, bb, stall;
        longint foot;
        tl.delete();
        c = blank(1'b0);
        c.start = 1'b1;
        c.r1 = r1;
        c.jt = jt;
        c.c2 = c2;
        c.ctrl[BErr] = prev_err;
        tl.push_back(c);
        c = blank(rs);
        c.ctrl[BBusy] = 1'b1;
        tl.push_back(c);
        rp   = r1 + r1 % 2;
        jp   = jt + jt % 2;
        cp   = c2 + c2 % 2;
        bb   = rp * jp;
        foot = longint'(rp) * jp + longint'(jp) * cp;
        if (r1 == 0 || jt == 0 || c2 == 0 || foot > MemH) begin
            c = blank(rs);
            c.ctrl[BDone] = 1'b1;
            c.ctrl[BErr]  = 1'b1;
            tl.push_back(c);
            c = blank(1'b0);
            c.ctrl[BErr] = 1'b1;
            tl.push_back(c);
            prev_err = 1'b1;
            return;
        end
        for (int ti = 0; ti < rp / 2; ti++) begin
            for (int tj = 0; tj < cp / 2; tj++) begin
                for (int tk = 0; tk < jp / 2; tk++) begin
                    for (int s = 0; s < 8; s++) begin
                        c = blank(rs);
                        c.ctrl[BBusy] = 1'b1;
                        c.ctrl[BRd]   = 1'b1;
                        if (s < 4) c.addr = (2 * ti + s / 2) * jp + 2 * tk + s % 2;
                        else       c.addr = bb + (2 * tk + (s / 2) % 2) * cp + 2 * tj + s % 2;
                        if (s > 0) begin
                            c.ctrl[BOpv] = 1'b1;
                            c.idx = s - 1;
                        end
                        tl.push_back(c);
                    end
                    c = blank(rs);
                    c.ctrl[BBusy] = 1'b1;
                    c.ctrl[BOpv]  = 1'b1;
                    c.idx = 7;
                    tl.push_back(c);
                    c = blank(rs);
                    c.ctrl[BBusy]  = 1'b1;
                    c.ctrl[BStep]  = 1'b1;
                    c.ctrl[BFirst] = (tk == 0);
                    c.ctrl[BLast]  = (tk == jp / 2 - 1);
                    tl.push_back(c);
                end
                stall = $urandom_range(slo, shi);
                for (int n = 0; n <= stall; n++) begin
                    c = blank(rs);
                    c.ctrl[BBusy] = 1'b1;
                    c.ctrl[BOv]   = 1'b1;
                    c.orow  = ti;
                    c.ocol  = tj;
                    c.ready = (n == stall);
                    tl.push_back(c);
                end
            end
        end
        c = blank(rs);
        c.ctrl[BDone] = 1'b1;
        tl.push_back(c);
        tl.push_back(blank(1'b0));
        prev_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctrl"}, 64'(obs_ctrl), 64'd0);
        check_eq({tag, "_addr"}, 64'(rd_addr), 64'd0);
        check_eq({tag, "_idx"}, 64'(op_idx), 64'd0);
        check_eq({tag, "_tile"}, 64'({out_row, out_col}), 64'd0);
    endtask

    // Called just after a posedge; returns just after a posedge.
    task automatic execute(input int abort_at);
        foreach (tl[n]) begin
            start     = tl[n].start;
            out_ready = tl[n].ready;
            row1      = DimW'(tl[n].r1);
            joint     = DimW'(tl[n].jt);
            col2      = DimW'(tl[n].c2);
            @(negedge clk);
            cyc = n;
            check_eq("ctrl", 64'(obs_ctrl), 64'(tl[n].ctrl));
            check_eq("rd_addr", 64'(rd_addr), 64'(tl[n].addr));
            check_eq("op_idx", 64'(op_idx), 64'(tl[n].idx));
            check_eq("tile", 64'({out_row, out_col}),
                     64'({tl[n].orow[15:0], tl[n].ocol[15:0]}));
            if (n == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("async_rst");
                start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_reset_outputs("held_rst");
                rst_n = 1'b1;
                prev_err = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_case(input int r1, input int jt, input int c2, input int slo,
                            input int shi, input bit rs, input int abort_at);
        build(r1, jt, c2, slo, shi, rs);
        execute(abort_at);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        row1      = '0;
        joint     = '0;
        col2      = '0;
        #12 check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_case(2, 2, 2, 0, 0, 1'b0, -1);         // single tile, single step
        run_case(3, 3, 3, 0, 0, 1'b0, -1);         // padded to 4, 4 tiles x 2 steps
        run_case(2, 2, 2, 5, 5, 1'b0, -1);         // write-back stalls 5 cycles
        run_case(2, 0, 2, 0, 0, 1'b0, -1);         // zero joint rejected
        run_case(0, 3, 3, 0, 0, 1'b0, -1);
        run_case(5, 5, 0, 0, 0, 1'b0, -1);
        run_case(46, 46, 46, 0, 0, 1'b0, -1);      // footprint 4232 overflows
        run_case(2, 2, 1998, 0, 0, 1'b0, -1);      // footprint exactly 4000 fits
        run_case(1, 1, 1999, 0, 0, 1'b0, -1);      // footprint 4004 overflows
        run_case(2, 2, 2, 0, 0, 1'b0, 6);          // reset in 5th fetch cycle
        run_case(2, 2, 2, 0, 0, 1'b0, -1);         // replay after reset
        run_case(3, 3, 3, 0, 0, 1'b1, -1);         // start spammed while busy
        for (int r = 0; r < 20; r++) begin
            run_case($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(1, 7),
                     0, 3, 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
